control_sequencer: RTL and testbench

Microprogram-free hardwired control unit for the BitCruncher accumulator datapath (PC, MAR, MBR, IR, BR, ACC, ALU). It steps a fetch/decode/execute state machine, reads the 8-bit opcode held in IR, waits on memory through a ready handshake, and drives the datapath load/enable lines, including C4, the IR load. One instance sits at the top of the CPU beside the datapath registers.

---
 rtl/bc_ctrl_pkg.sv | 37 +++
 rtl/ctrl_decode.sv | 39 +++
 rtl/control_sequencer.sv | 86 ++++++++
 tb/tb_control_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bc_ctrl_pkg.sv
// rtl/bc_ctrl_pkg.sv - shared encodings for the BitCruncher control sequencer
package bc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_DEC, S_ADR, S_RD,
    S_LBR, S_ALU, S_SD, S_WR, S_JMP, S_HALT
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMP    = 8'h05;
  localparam logic [7:0] OP_JMPGEZ = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;

  localparam int C0 = 0;
  localparam int C1 = 1;
  localparam int C2 = 2;
  localparam int C3 = 3;
  localparam int C4 = 4;
  localparam int C5 = 5;
  localparam int C6 = 6;
  localparam int C7 = 7;
  localparam int C8 = 8;
  localparam int C9 = 9;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  function automatic logic is_legal(input logic [7:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational state/opcode to datapath control decode
module ctrl_decode
  import bc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [7:0] opcode,
  output logic [9:0] ctrl,
  output logic [1:0] alu_op
);

  always_comb begin
    ctrl   = '0;
    alu_op = ALU_PASS;
    case (state)
      S_F0:  ctrl[C0] = 1'b1;
      S_F1:  ctrl[C1] = 1'b1;
      S_F2: begin
        ctrl[C4] = 1'b1;
        ctrl[C2] = 1'b1;
      end
      S_ADR: ctrl[C5] = 1'b1;
      S_RD:  ctrl[C1] = 1'b1;
      S_LBR: ctrl[C6] = 1'b1;
      S_ALU: begin
        ctrl[C7] = 1'b1;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
      end
      S_SD:  ctrl[C8] = 1'b1;
      S_WR:  ctrl[C3] = 1'b1;
      S_JMP: ctrl[C9] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer for the accumulator datapath
module control_sequencer
  import bc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir_in,
  input  logic       acc_neg,
  input  logic       mem_rdy,
  output logic [9:0] ctrl,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       halted,
  output logic       illegal
);

  state_t     state;
  state_t     next_state;
  logic [9:0] ctrl_dec;
  logic [1:0] alu_dec;
  logic       done_raw;
  logic       ill_raw;

  always_ff @(posedge clk) begin
    if (rst) state <= S_F0;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_F0:  next_state = S_F1;
      S_F1:  if (mem_rdy) next_state = S_F2;
      S_F2:  next_state = S_DEC;
      S_DEC: begin
        case (ir_in)
          OP_LOAD, OP_ADD, OP_SUB, OP_STORE: next_state = S_ADR;
          OP_JMP:    next_state = S_JMP;
          OP_JMPGEZ: next_state = acc_neg ? S_F0 : S_JMP;
          OP_HALT:   next_state = S_HALT;
          default:   next_state = S_F0;
        endcase
      end
      // IR is stable after F2, so ADR can still steer on the opcode
      S_ADR: next_state = (ir_in == OP_STORE) ? S_SD : S_RD;
      S_RD:  if (mem_rdy) next_state = S_LBR;
      S_LBR: next_state = S_ALU;
      S_ALU: next_state = S_F0;
      S_SD:  next_state = S_WR;
      S_WR:  if (mem_rdy) next_state = S_F0;
      S_JMP: next_state = S_F0;
      S_HALT: next_state = S_HALT;
      default: next_state = S_F0;
    endcase
  end

  always_comb begin
    done_raw = 1'b0;
    ill_raw  = 1'b0;
    case (state)
      S_ALU, S_JMP: done_raw = 1'b1;
      S_WR:  done_raw = mem_rdy;
      S_DEC: begin
        ill_raw  = !is_legal(ir_in);
        done_raw = (ir_in == OP_NOP) || !is_legal(ir_in) ||
                   ((ir_in == OP_JMPGEZ) && acc_neg);
      end
      default: ;
    endcase
  end

  ctrl_decode u_decode (
    .state  (state),
    .opcode (ir_in),
    .ctrl   (ctrl_dec),
    .alu_op (alu_dec)
  );

  // Outputs are forced quiet during the reset cycle itself
  assign ctrl       = rst ? '0 : ctrl_dec;
  assign alu_op     = rst ? ALU_PASS : alu_dec;
  assign instr_done = !rst && done_raw;
  assign illegal    = !rst && ill_raw;
  assign halted     = !rst && (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
  import bc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir_in;
  logic       acc_neg;
  logic       mem_rdy;
  logic [9:0] ctrl;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       halted;
  logic       illegal;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .ir_in      (ir_in),
    .acc_neg    (acc_neg),
    .mem_rdy    (mem_rdy),
    .ctrl       (ctrl),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal    (illegal)
  );

  typedef struct {
    int cyc; int c1; int c3; int c4; int c7; int c9; int alu; int ill;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  bit   mon_on = 1'b0;
  localparam int N_INSTR = 80;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level reference: cycle/line counts from opcode, branch and wait counts
  function automatic exp_t model(input int op, input bit an, input int fw, input int dw);
    exp_t e;
    bit las = (op == 1) || (op == 3) || (op == 4);
    bit st  = (op == 2);
    bit jmp = (op == 5) || (op == 6 && !an);
    e.cyc = 4 + fw;
    if (las)      e.cyc += 4 + dw;
    else if (st)  e.cyc += 3 + dw;
    else if (jmp) e.cyc += 1;
    e.c1  = 1 + fw + (las ? 1 + dw : 0);
    e.c3  = st ? 1 + dw : 0;
    e.c4  = 1;
    e.c7  = las ? 1 : 0;
    e.c9  = jmp ? 1 : 0;
    e.alu = (op == 3) ? 1 : (op == 4) ? 2 : 0;
    e.ill = (op > 7) ? 1 : 0;
    return e;
  endfunction

  // Memory/IR environment, stepped once per cycle just after the edge
  int pend_op, fw, dw, left, acc_i;
  bit pend_an, busy;

  task automatic env_step();
    if (ctrl[C0]) begin
      int r = $urandom_range(0, 9);
      pend_op = (r <= 6) ? r : $urandom_range(8, 255);
      pend_an = 1'($urandom);
      fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      dw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      q.push_back(model(pend_op, pend_an, fw, dw));
      acc_i = 0;
      busy = 1'b0;
      mem_rdy = 1'($urandom);
    end else if (ctrl[C1] || ctrl[C3]) begin
      if (!busy) begin
        busy = 1'b1;
        left = (acc_i == 0) ? fw : dw;
      end
      if (left > 0) begin
        mem_rdy = 1'b0;
        left--;
      end else begin
        mem_rdy = 1'b1;
        busy = 1'b0;
        acc_i++;
      end
    end else begin
      mem_rdy = 1'($urandom);
      if (ctrl[C4]) begin
        ir_in = pend_op[7:0];
        acc_neg = pend_an;
      end
    end
  endtask

  // Monitor: accumulates per-instruction activity, pops on instr_done
  initial begin
    int cyc, c1, c3, c4, c7, c9, aluv, ill, bad;
    exp_t e;
    cyc = 0; c1 = 0; c3 = 0; c4 = 0; c7 = 0; c9 = 0; aluv = 0; ill = 0; bad = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (ctrl[C0]) begin
          cyc = 0; c1 = 0; c3 = 0; c4 = 0; c7 = 0; c9 = 0; aluv = 0; ill = 0; bad = 0;
        end
        cyc++;
        c1 += int'(ctrl[C1]);
        c3 += int'(ctrl[C3]);
        c4 += int'(ctrl[C4]);
        c7 += int'(ctrl[C7]);
        c9 += int'(ctrl[C9]);
        ill += int'(illegal);
        if (ctrl[C7]) aluv = int'(alu_op);
        else if (alu_op != 2'b00) bad++;
        if (halted) bad++;
        if (instr_done) begin
          if (q.size() == 0) begin
            check("sb_unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("cycles", cyc, e.cyc);
            check("c1_cycles", c1, e.c1);
            check("c3_cycles", c3, e.c3);
            check("c4_pulses", c4, e.c4);
            check("c7_pulses", c7, e.c7);
            check("c9_pulses", c9, e.c9);
            check("alu_op", aluv, e.alu);
            check("illegal", ill, e.ill);
            check("stray_outputs", bad, 0);
            done_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int budget, bad_h;
    rst = 1'b1; mem_rdy = 1'b0; ir_in = 8'h3F; acc_neg = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", int'(ctrl), 0);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_instr_done", int'(instr_done), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_illegal", int'(illegal), 0);

    // Randomized instruction stream
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;
    #1 env_step();
    budget = 0;
    while (done_cnt < N_INSTR && budget < 8000) begin
      @(posedge clk); #1;
      env_step();
      budget++;
    end
    check("instr_count", done_cnt, N_INSTR);
    mon_on = 1'b0;

    // Reset in the middle of an RD wait
    @(posedge clk); #1;
    rst = 1'b1; mem_rdy = 1'b1; ir_in = OP_LOAD; acc_neg = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 mem_rdy = 1'b0;
    @(negedge clk);
    check("adr_ctrl", int'(ctrl), 'h020);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_wait_ctrl", int'(ctrl), 'h002);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_rd_ctrl", int'(ctrl), 0);
    @(posedge clk); #1 begin rst = 1'b0; mem_rdy = 1'b1; ir_in = OP_HALT; end
    @(negedge clk);
    check("restart_f0", int'(ctrl), 'h001);

    // HALT holds until reset
    repeat (4) @(posedge clk);
    bad_h = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (!halted || ctrl != 10'h000 || instr_done) bad_h++;
    end
    check("halt_hold", bad_h, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_halt_halted", int'(halted), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("halt_exit_f0", int'(ctrl), 'h001);
    check("halt_exit_halted", int'(halted), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
